// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank controller: controller states and
// default bank geometry.
package regbank_pkg;

    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefDataW = 32;

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a writing
// instruction, cleared when its writeback leaves the write port. Register 0
// is hardwired and never tracked.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic                     clr_i,
    input  logic [ADDR_W-1:0]        clr_addr_i,
    output logic [(2**ADDR_W)-1:0]   pending_o
);

    localparam int unsigned NReg = 2 ** ADDR_W;

    logic [NReg-1:0] pending_q, pending_d;
    logic [NReg-1:0] set_mask, clr_mask;

    // Set and clear of distinct bits in one cycle both take effect.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i && (set_addr_i != '0)) begin
            set_mask[set_addr_i] = 1'b1;
        end
        if (clr_i && (clr_addr_i != '0)) begin
            clr_mask[clr_addr_i] = 1'b1;
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/regbank_ctrl.sv
// Register-bank controller: decode issue with RAW/WAW hazard stalls, fixed
// priority writeback arbitration (memory over ALU) and a drain handshake.
// Optional feature: define REGBANK_CLEAR_EN to zero registers 1..N-1 during
// INIT; otherwise INIT lasts a single cycle.
module regbank_ctrl
    import regbank_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic                     clk,
    input  logic                     reset,
    // Decode issue
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [ADDR_W-1:0]        dec_addr_a,
    input  logic [ADDR_W-1:0]        dec_addr_b,
    input  logic [ADDR_W-1:0]        dec_addr_d,
    input  logic                     dec_we,
    // Read port to the bank
    output logic                     getRegs,
    output logic [ADDR_W-1:0]        addr_a,
    output logic [ADDR_W-1:0]        addr_b,
    // ALU writeback source
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     alu_we_high,
    // Memory-load writeback source
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    // Write port to the bank
    output logic                     writeBack,
    output logic                     we,
    output logic                     we_high,
    output logic                     read_mem,
    output logic [ADDR_W-1:0]        addr_d,
    output logic [DATA_W-1:0]        data_d,
    // Drain handshake and scoreboard view
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic [(2**ADDR_W)-1:0]   pending
);

    state_e state_q, state_d;

    logic              getregs_q, getregs_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;

    logic              wb_q, wb_d;
    logic              we_q, we_d;
    logic              we_high_q, we_high_d;
    logic              read_mem_q, read_mem_d;
    logic [ADDR_W-1:0] addr_d_q, addr_d_d;
    logic [DATA_W-1:0] data_d_q, data_d_d;

`ifdef REGBANK_CLEAR_EN
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
`endif

    logic run_or_drain;
    logic haz_a, haz_b, haz_d;
    logic issue_acc, mem_acc, alu_acc, wr_acc;

    // Hazard check and source handshakes; address 0 never stalls.
    always_comb begin
        run_or_drain = (state_q == StRun) || (state_q == StDrain);
        haz_a        = (dec_addr_a != '0) && pending[dec_addr_a];
        haz_b        = (dec_addr_b != '0) && pending[dec_addr_b];
        haz_d        = dec_we && (dec_addr_d != '0) && pending[dec_addr_d];
        dec_ready    = (state_q == StRun) && !haz_a && !haz_b && !haz_d;
        issue_acc    = dec_valid && dec_ready;
        mem_ready    = run_or_drain;
        alu_ready    = run_or_drain && !mem_valid;
        mem_acc      = mem_valid && mem_ready;
        alu_acc      = alu_valid && alu_ready;
        wr_acc       = mem_acc || alu_acc;
    end

    regbank_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_i      (issue_acc && dec_we),
        .set_addr_i (dec_addr_d),
        .clr_i      (wb_q),
        .clr_addr_i (addr_d_q),
        .pending_o  (pending)
    );

    // FSM next-state and drain completion.
    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
`ifdef REGBANK_CLEAR_EN
        init_cnt_d = init_cnt_q;
`endif
        case (state_q)
            StInit: begin
`ifdef REGBANK_CLEAR_EN
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = StRun;
                end
`else
                state_d = StRun;
`endif
            end
            StRun: begin
                if (drain_req) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Done only once nothing is pending, on the port, or entering it.
                if ((pending == '0) && !wb_q && !wr_acc) begin
                    drain_done = 1'b1;
                    state_d    = StRun;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Next values for the registered read and write ports.
    always_comb begin
        getregs_d  = issue_acc;
        addr_a_d   = issue_acc ? dec_addr_a : addr_a_q;
        addr_b_d   = issue_acc ? dec_addr_b : addr_b_q;
        wb_d       = 1'b0;
        we_d       = 1'b0;
        we_high_d  = 1'b0;
        read_mem_d = 1'b0;
        addr_d_d   = addr_d_q;
        data_d_d   = data_d_q;
        if (mem_acc) begin
            wb_d       = 1'b1;
            we_d       = (mem_addr != '0);
            read_mem_d = 1'b1;
            addr_d_d   = mem_addr;
            data_d_d   = mem_data;
        end else if (alu_acc) begin
            wb_d      = 1'b1;
            we_d      = (alu_addr != '0);
            we_high_d = alu_we_high;
            addr_d_d  = alu_addr;
            data_d_d  = alu_data;
        end
`ifdef REGBANK_CLEAR_EN
        else if (state_q == StInit) begin
            wb_d     = 1'b1;
            we_d     = 1'b1;
            addr_d_d = init_cnt_q;
            data_d_d = '0;
        end
`endif
    end

    // State and output registers; reset discards all in-flight work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StInit;
            getregs_q  <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            wb_q       <= 1'b0;
            we_q       <= 1'b0;
            we_high_q  <= 1'b0;
            read_mem_q <= 1'b0;
            addr_d_q   <= '0;
            data_d_q   <= '0;
`ifdef REGBANK_CLEAR_EN
            init_cnt_q <= ADDR_W'(1);
`endif
        end else begin
            state_q    <= state_d;
            getregs_q  <= getregs_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            wb_q       <= wb_d;
            we_q       <= we_d;
            we_high_q  <= we_high_d;
            read_mem_q <= read_mem_d;
            addr_d_q   <= addr_d_d;
            data_d_q   <= data_d_d;
`ifdef REGBANK_CLEAR_EN
            init_cnt_q <= init_cnt_d;
`endif
        end
    end

    assign getRegs   = getregs_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign writeBack = wb_q;
    assign we        = we_q;
    assign we_high   = we_high_q;
    assign read_mem  = read_mem_q;
    assign addr_d    = addr_d_q;
    assign data_d    = data_d_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl in its default build (REGBANK_CLEAR_EN off).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_regbank_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dec_valid = 1'b0, dec_ready, dec_we = 1'b0;
    logic [3:0]  dec_addr_a = '0, dec_addr_b = '0, dec_addr_d = '0;
    logic        getRegs;
    logic [3:0]  addr_a, addr_b;
    logic        alu_valid = 1'b0, alu_ready, alu_we_high = 1'b0;
    logic [3:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0, mem_ready;
    logic [3:0]  mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        writeBack, we, we_high, read_mem;
    logic [3:0]  addr_d;
    logic [31:0] data_d;
    logic        drain_req = 1'b0, drain_done;
    logic [15:0] pending;

    int n_checks = 0;
    int n_fail = 0;

    regbank_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_addr_a (dec_addr_a),
        .dec_addr_b (dec_addr_b),
        .dec_addr_d (dec_addr_d),
        .dec_we     (dec_we),
        .getRegs    (getRegs),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_we_high(alu_we_high),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .writeBack  (writeBack),
        .we         (we),
        .we_high    (we_high),
        .read_mem   (read_mem),
        .addr_d     (addr_d),
        .data_d     (data_d),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic w);
        dec_valid = 1'b1; dec_addr_a = a; dec_addr_b = b; dec_addr_d = d; dec_we = w;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if ({dec_ready, alu_ready, mem_ready, getRegs, writeBack, we, we_high,
                         read_mem, drain_done} !== 9'b0) begin n_fail++;
            $display("FAIL rst_ctrl_outs: got %b want 0", {dec_ready, alu_ready, mem_ready,
                     getRegs, writeBack, we, we_high, read_mem, drain_done}); end
        n_checks++; if ({pending, addr_a, addr_b, addr_d, data_d} !== '0) begin n_fail++;
            $display("FAIL rst_data_outs: pending %h addr_d %h data_d %h want 0",
                     pending, addr_d, data_d); end
        reset = 1'b1;
        #1;
        n_checks++; if (dec_ready !== 1'b0) begin n_fail++;
            $display("FAIL init_ready: got %b want 0", dec_ready); end
        @(negedge clk); #1;
        n_checks++; if ({dec_ready, mem_ready, alu_ready, writeBack} !== 4'b1110) begin n_fail++;
            $display("FAIL run_ready: got %b want 1110", {dec_ready, mem_ready, alu_ready,
                     writeBack}); end
    endtask

    task automatic test_hazard();
        @(negedge clk); issue(4'd1, 4'd2, 4'd3, 1'b1); #1;
        n_checks++; if (dec_ready !== 1'b1) begin n_fail++;
            $display("FAIL haz_issue_ready: got %b want 1", dec_ready); end
        @(negedge clk); issue(4'd3, 4'd0, 4'd0, 1'b0); #1;
        n_checks++; if ({getRegs, addr_a, addr_b} !== {1'b1, 4'd1, 4'd2}) begin n_fail++;
            $display("FAIL haz_getregs: got %b/%h/%h want 1/1/2", getRegs, addr_a, addr_b); end
        n_checks++; if (pending !== 16'h0008) begin n_fail++;
            $display("FAIL haz_pending_set: got %h want 0008", pending); end
        n_checks++; if (dec_ready !== 1'b0) begin n_fail++;
            $display("FAIL haz_stall: got %b want 0", dec_ready); end
        @(negedge clk);
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h1234_5678; alu_we_high = 1'b1; #1;
        n_checks++; if ({getRegs, dec_ready, alu_ready} !== 3'b001) begin n_fail++;
            $display("FAIL haz_stall2: getRegs/dec_ready/alu_ready %b want 001",
                     {getRegs, dec_ready, alu_ready}); end
        @(negedge clk); alu_valid = 1'b0; alu_we_high = 1'b0; #1;
        n_checks++; if ({writeBack, we, we_high, read_mem, addr_d, data_d} !==
                        {4'b1110, 4'd3, 32'h1234_5678}) begin n_fail++;
            $display("FAIL haz_alu_wb: got %b %h %h want 1110 3 12345678",
                     {writeBack, we, we_high, read_mem}, addr_d, data_d); end
        n_checks++; if ({pending, dec_ready} !== {16'h0008, 1'b0}) begin n_fail++;
            $display("FAIL haz_early_clear: pending %h ready %b want 0008 0", pending,
                     dec_ready); end
        @(negedge clk); #1;
        n_checks++; if ({pending, writeBack, dec_ready} !== {16'h0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL haz_release: pending %h wb %b ready %b want 0000 0 1", pending,
                     writeBack, dec_ready); end
        @(negedge clk); dec_valid = 1'b0; #1;
        n_checks++; if ({getRegs, addr_a} !== {1'b1, 4'd3}) begin n_fail++;
            $display("FAIL haz_reissue: got %b/%h want 1/3", getRegs, addr_a); end
    endtask

    task automatic test_arbitration();
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 32'hA5A5_A5A5;
        alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 32'h0000_0066; alu_we_high = 1'b1; #1;
        n_checks++; if ({mem_ready, alu_ready} !== 2'b10) begin n_fail++;
            $display("FAIL arb_ready: got %b want 10", {mem_ready, alu_ready}); end
        @(negedge clk); mem_valid = 1'b0; #1;
        n_checks++; if ({writeBack, read_mem, we_high, addr_d, data_d} !==
                        {3'b110, 4'd5, 32'hA5A5_A5A5}) begin n_fail++;
            $display("FAIL arb_mem_first: got %b %h %h want 110 5 a5a5a5a5",
                     {writeBack, read_mem, we_high}, addr_d, data_d); end
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++;
            $display("FAIL arb_alu_ready: got %b want 1", alu_ready); end
        @(negedge clk); alu_valid = 1'b0; alu_we_high = 1'b0; #1;
        n_checks++; if ({writeBack, read_mem, we_high, addr_d, data_d} !==
                        {3'b101, 4'd6, 32'h0000_0066}) begin n_fail++;
            $display("FAIL arb_alu_second: got %b %h %h want 101 6 66",
                     {writeBack, read_mem, we_high}, addr_d, data_d); end
        @(negedge clk); #1;
        n_checks++; if (writeBack !== 1'b0) begin n_fail++;
            $display("FAIL arb_single_pulse: got %b want 0", writeBack); end
    endtask

    task automatic test_addr0();
        @(negedge clk); issue(4'd0, 4'd0, 4'd9, 1'b1); #1;
        n_checks++; if (dec_ready !== 1'b1) begin n_fail++;
            $display("FAIL a0_issue_ready: got %b want 1", dec_ready); end
        @(negedge clk); dec_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 32'hDEAD_BEEF; #1;
        n_checks++; if ({pending, alu_ready} !== {16'h0200, 1'b1}) begin n_fail++;
            $display("FAIL a0_pre: pending %h alu_ready %b want 0200 1", pending,
                     alu_ready); end
        @(negedge clk); alu_valid = 1'b0; #1;
        n_checks++; if ({writeBack, we, read_mem, addr_d, data_d} !==
                        {3'b100, 4'd0, 32'hDEAD_BEEF}) begin n_fail++;
            $display("FAIL a0_wb: got %b %h %h want 100 0 deadbeef",
                     {writeBack, we, read_mem}, addr_d, data_d); end
        @(negedge clk); mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'h0; #1;
        n_checks++; if ({pending, writeBack} !== {16'h0200, 1'b0}) begin n_fail++;
            $display("FAIL a0_pending_kept: pending %h wb %b want 0200 0", pending,
                     writeBack); end
        @(negedge clk); mem_valid = 1'b0; #1;
        n_checks++; if ({writeBack, we, addr_d} !== {2'b11, 4'd9}) begin n_fail++;
            $display("FAIL a0_wb9: got %b %h want 11 9", {writeBack, we}, addr_d); end
        @(negedge clk); #1;
        n_checks++; if (pending !== 16'h0000) begin n_fail++;
            $display("FAIL a0_clear9: got %h want 0000", pending); end
    endtask

    task automatic test_drain();
        @(negedge clk); issue(4'd0, 4'd0, 4'd2, 1'b1); #1;
        n_checks++; if (dec_ready !== 1'b1) begin n_fail++;
            $display("FAIL dr_issue2: got %b want 1", dec_ready); end
        @(negedge clk); issue(4'd0, 4'd0, 4'd7, 1'b1); #1;
        n_checks++; if ({dec_ready, getRegs} !== 2'b11) begin n_fail++;
            $display("FAIL dr_issue7_b2b: got %b want 11", {dec_ready, getRegs}); end
        @(negedge clk); dec_valid = 1'b0; drain_req = 1'b1; #1;
        n_checks++; if ({pending, getRegs} !== {16'h0084, 1'b1}) begin n_fail++;
            $display("FAIL dr_pending: got %h/%b want 0084/1", pending, getRegs); end
        @(negedge clk); drain_req = 1'b0; issue(4'd0, 4'd0, 4'd0, 1'b0);
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h22; #1;
        n_checks++; if ({dec_ready, drain_done, mem_ready} !== 3'b001) begin n_fail++;
            $display("FAIL dr_in_drain: ready/done/mem_ready %b want 001",
                     {dec_ready, drain_done, mem_ready}); end
        @(negedge clk); mem_addr = 4'd7; mem_data = 32'h77; #1;
        n_checks++; if ({writeBack, addr_d, pending, drain_done} !==
                        {1'b1, 4'd2, 16'h0084, 1'b0}) begin n_fail++;
            $display("FAIL dr_wb2: wb %b addr %h pending %h done %b", writeBack, addr_d,
                     pending, drain_done); end
        @(negedge clk); mem_valid = 1'b0; #1;
        n_checks++; if ({writeBack, addr_d, pending, drain_done} !==
                        {1'b1, 4'd7, 16'h0080, 1'b0}) begin n_fail++;
            $display("FAIL dr_wb7: wb %b addr %h pending %h done %b", writeBack, addr_d,
                     pending, drain_done); end
        @(negedge clk); #1;
        n_checks++; if ({pending, writeBack, drain_done, dec_ready} !==
                        {16'h0000, 3'b010}) begin n_fail++;
            $display("FAIL dr_done: pending %h wb %b done %b ready %b want 0000 0 1 0",
                     pending, writeBack, drain_done, dec_ready); end
        @(negedge clk); dec_valid = 1'b0; #1;
        n_checks++; if ({drain_done, dec_ready} !== 2'b01) begin n_fail++;
            $display("FAIL dr_back_run: done/ready %b want 01", {drain_done, dec_ready}); end
    endtask

    task automatic test_reset_in_drain();
        @(negedge clk); issue(4'd0, 4'd0, 4'd4, 1'b1); #1;
        n_checks++; if (dec_ready !== 1'b1) begin n_fail++;
            $display("FAIL rd_issue4: got %b want 1", dec_ready); end
        @(negedge clk); dec_valid = 1'b0; drain_req = 1'b1; #1;
        n_checks++; if (pending !== 16'h0010) begin n_fail++;
            $display("FAIL rd_pending: got %h want 0010", pending); end
        @(negedge clk); drain_req = 1'b0; mem_valid = 1'b1; mem_addr = 4'd11;
        mem_data = 32'hBB; #1;
        n_checks++; if ({mem_ready, dec_ready} !== 2'b10) begin n_fail++;
            $display("FAIL rd_drain: mem_ready/dec_ready %b want 10", {mem_ready, dec_ready});
        end
        @(negedge clk); mem_valid = 1'b0; #1;
        n_checks++; if (writeBack !== 1'b1) begin n_fail++;
            $display("FAIL rd_inflight: got %b want 1", writeBack); end
        reset = 1'b0; #1;
        n_checks++; if ({dec_ready, alu_ready, mem_ready, getRegs, writeBack, we, we_high,
                         read_mem, drain_done} !== 9'b0) begin n_fail++;
            $display("FAIL rd_async_outs: got %b want 0", {dec_ready, alu_ready, mem_ready,
                     getRegs, writeBack, we, we_high, read_mem, drain_done}); end
        n_checks++; if ({pending, addr_d, data_d} !== '0) begin n_fail++;
            $display("FAIL rd_async_data: pending %h addr_d %h data_d %h want 0", pending,
                     addr_d, data_d); end
        @(negedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++; if ({writeBack, drain_done} !== 2'b00) begin n_fail++;
                $display("FAIL rd_no_stale_%0d: wb/done %b want 00", i,
                         {writeBack, drain_done}); end
        end
        n_checks++; if (dec_ready !== 1'b1) begin n_fail++;
            $display("FAIL rd_rerun: got %b want 1", dec_ready); end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_arbitration();
        test_addr0();
        test_drain();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_ctrl.md
REGBANK_CTRL -- requirements
Module: regbank_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register address width; register count is 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports dec_valid/dec_ready, input/output, 1/1, decode issue handshake.
REQ-006 SHALL have ports dec_addr_a, dec_addr_b, dec_addr_d, input, ADDR_W each, plus dec_we, input, 1: issue sources, destination, write intent.
REQ-007 SHALL have ports getRegs, output, 1, and addr_a, addr_b, output, ADDR_W: registered read strobe and addresses to the register bank.
REQ-008 SHALL have ports alu_valid/alu_ready, 1/1, plus alu_addr ADDR_W, alu_data DATA_W, alu_we_high 1, all inputs except ready: ALU writeback source.
REQ-009 SHALL have ports mem_valid/mem_ready, 1/1, plus mem_addr ADDR_W, mem_data DATA_W, inputs except ready: memory-load writeback source.
REQ-010 SHALL have outputs writeBack 1, we 1, we_high 1, read_mem 1, addr_d ADDR_W, data_d DATA_W: registered write port to the register bank.
REQ-011 SHALL have ports drain_req, input, 1, and drain_done, output, 1: drain handshake.
REQ-012 SHALL have port pending, output, 2**ADDR_W: scoreboard view.

Function
REQ-013 SHALL implement states INIT, RUN, DRAIN.
REQ-014 Scoreboard bit n SHALL set at the posedge accepting an issue with dec_we=1 and dec_addr_d=n, n!=0.
REQ-015 Bit n SHALL clear at the posedge ending the cycle in which writeBack=1 with addr_d=n, never earlier.
REQ-016 dec_ready SHALL be 1 only in RUN with no pending bit set for nonzero dec_addr_a, dec_addr_b, or (if dec_we) dec_addr_d; address 0 never stalls.
REQ-017 An accepted issue SHALL produce getRegs=1 with captured addr_a/addr_b in the next cycle, for exactly one cycle; otherwise getRegs=0.
REQ-018 Write arbitration SHALL be fixed priority mem over alu; mem_ready=1 in RUN/DRAIN, alu_ready=1 in RUN/DRAIN when mem_valid=0.
REQ-019 An accepted write SHALL produce writeBack=1 for exactly one cycle in the next cycle, with addr_d/data_d captured; read_mem=1 and we_high=0 for mem, read_mem=0 and we_high=alu_we_high for alu.
REQ-020 we SHALL equal writeBack except we=0 when addr_d=0; the write is still consumed.
REQ-021 Simultaneous set and clear of one bit cannot occur (WAW stall); set of one bit and clear of another in one cycle SHALL both take effect.
REQ-022 drain_req=1 in RUN SHALL move to DRAIN; DRAIN holds dec_ready=0, still accepts writes.
REQ-023 In DRAIN, when pending=0 and no writeBack is in flight, drain_done SHALL pulse one cycle and state SHALL return to RUN; drain_req in INIT is held until RUN.

Reset
REQ-024 reset low SHALL asynchronously force pending=0, all outputs 0 (dec_ready, alu_ready, mem_ready included), state INIT, init counter 1.
REQ-025 Reset mid-drain or mid-write SHALL discard all in-flight work; no writeBack after release until a new acceptance.

Configuration
REQ-026 With REGBANK_CLEAR_EN defined, INIT SHALL emit writeBack=we=1, data_d=0, read_mem=we_high=0, addr_d=1..(2**ADDR_W-1), one per cycle, then enter RUN; sources not ready during INIT.
REQ-027 Without REGBANK_CLEAR_EN, INIT SHALL last one cycle after reset release, emitting no writes, then enter RUN.

Structure
REQ-028 State encoding and the default ADDR_W/DATA_W constants SHALL live in shared package regbank_pkg.
REQ-029 Scoreboard SHALL be sub-module regbank_scoreboard (set port, clear port, pending vector); arbitration and FSM stay in regbank_ctrl.

Verification
REQ-030 Issue d=3 we=1, then issue a=3 -> dec_ready=0 until the posedge after writeBack with addr_d=3, then getRegs next cycle with addr_a=3.
REQ-031 alu_valid and mem_valid together, mem_addr=5, alu_addr=6 -> writeBack read_mem=1 addr_d=5 first, alu write addr_d=6 one cycle later.
REQ-032 alu write addr 0, data 0xDEADBEEF -> writeBack=1, we=0, alu consumed, pending unchanged.
REQ-033 pending bits 2,7 set, drain_req=1 -> dec_ready=0; drain_done one cycle after second clear; back in RUN.
REQ-034 With REGBANK_CLEAR_EN, release reset -> 15 writes data_d=0 addr 1..15, then dec_ready=1; without it, dec_ready=1 on second cycle.
REQ-035 Assert reset during DRAIN with bit 4 pending -> pending=0, all outputs 0 immediately, no drain_done.
